alu_issue_arbiter: RTL

- Shares one 3-stage pipelined 8-bit arithmetic unit (add/sub/mul/div, 16-bit result) between NUM_REQ requesters.
- Grants at most one request per cycle using round-robin priority and drives the unit's operand and op inputs from a register.
- Tracks each issued operation's requester id through a tag shift register matched to the unit's latency.
- Returns each result to its requester with the id attached and a divide-by-zero flag.

---
 rtl/alu_issue_arbiter_pkg.sv | 26 ++
 rtl/alu_issue_arbiter_rr_arbiter.sv | 38 +++
 rtl/alu_issue_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared definitions for the ALU issue arbiter: op codes, datapath widths and
// the tag that follows each issued operation through the unit's pipeline.
package alu_issue_arbiter_pkg;

    localparam int OPND_W   = 8;
    localparam int RES_W    = 16;
    localparam int TAG_ID_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                dz;
    } tag_t;

    function automatic logic is_div_zero(input logic [1:0] op, input logic [OPND_W-1:0] b);
        return (op == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after 'pointer' wins.
// The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int pri;
    int best;

    // pri is the distance past the pointer; distance 0 is the slot right after it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        pri       = 0;
        best      = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            pri = (i + NUM_REQ - 1 - int'(pointer)) % NUM_REQ;
            if (req[i] && (pri < best)) begin
                best      = pri;
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        if (hold) begin
            grant     = '0;
            grant_idx = '0;
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one pipelined 8-bit arithmetic unit between NUM_REQ requesters and
// routes each result back to its requester with a divide-by-zero flag.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic                      hold,
    output logic [OPND_W-1:0]         alu_a,
    output logic [OPND_W-1:0]         alu_b,
    output logic [1:0]                alu_op,
    input  logic [RES_W-1:0]          alu_result,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      rsp_dz,
    output logic                      busy
);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               handshake;
    logic [OPND_W-1:0]  sel_a;
    logic [OPND_W-1:0]  sel_b;
    logic [1:0]         sel_op;
    tag_t               new_tag;
    tag_t [ALU_LAT:0]   tag_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .hold      (hold),
        .pointer   (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*OPND_W +: OPND_W];
                sel_b  = req_b[i*OPND_W +: OPND_W];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    always_comb begin
        new_tag       = '0;
        new_tag.valid = 1'b1;
        new_tag.id    = TAG_ID_W'(grant_idx);
        new_tag.dz    = is_div_zero(sel_op, sel_b);
    end

    // Operands hold their last value between issues; only a handshake moves the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            ptr    <= ID_W'(NUM_REQ - 1);
        end else if (handshake) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            ptr    <= grant_idx;
        end
    end

    // Stage 0 sits beside the issue register; stage ALU_LAT lines up with alu_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= handshake ? new_tag : '0;
            for (int s = 1; s <= ALU_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= ALU_LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    assign rsp_valid = tag_q[ALU_LAT].valid;
    assign rsp_id    = ID_W'(tag_q[ALU_LAT].id);
    assign rsp_dz    = tag_q[ALU_LAT].dz;
    assign rsp_data  = alu_result;

endmodule
